// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants: opcodes, encoder class codes, NOP word,
// the encoder field bundle and the encoder FSM state type.
// The helper fits_signed is only compiled when IMM_RANGE_CHECK_EN is defined.
package rv_isa_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;

  // Major opcodes, also used by the decoder
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  // Encoder instruction class codes
  localparam logic [CLASS_W-1:0] ENC_LUI    = 4'd0;
  localparam logic [CLASS_W-1:0] ENC_AUIPC  = 4'd1;
  localparam logic [CLASS_W-1:0] ENC_JAL    = 4'd2;
  localparam logic [CLASS_W-1:0] ENC_JALR   = 4'd3;
  localparam logic [CLASS_W-1:0] ENC_BRANCH = 4'd4;
  localparam logic [CLASS_W-1:0] ENC_LOAD   = 4'd5;
  localparam logic [CLASS_W-1:0] ENC_STORE  = 4'd6;
  localparam logic [CLASS_W-1:0] ENC_OPIMM  = 4'd7;
  localparam logic [CLASS_W-1:0] ENC_OP     = 4'd8;

  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_SRX = 3'b101;

  localparam logic [F7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT  = 7'b0100000;

  // ADDI x0,x0,0
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  // One instruction worth of unencoded fields
  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [F3_W-1:0]    funct3;
    logic               alt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [XLEN-1:0]    imm;
  } enc_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

`ifdef IMM_RANGE_CHECK_EN
  // True when v is representable as a signed value of (msb+1) bits
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned msb);
    logic [XLEN-1:0] s;
    s = XLEN'($signed(v) >>> msb);
    return (s == '0) || (s == '1);
  endfunction
`endif

endpackage

// File: rtl/rv_field_pack.sv
// Combinational RV32I field packer: field bundle -> 32-bit instruction word,
// plus an error flag for unknown classes and (with IMM_RANGE_CHECK_EN)
// immediates that do not fit their encoding.
module rv_field_pack
  import rv_isa_pkg::*;
(
  input  enc_fields_t      fields,
  output logic [XLEN-1:0]  word_c,
  output logic             err_c
);

  logic            is_shift;
  logic [F7_W-1:0] f7;
  logic            bad_class;
  logic            range_err;

  assign is_shift = (fields.funct3 == F3_SLL) || (fields.funct3 == F3_SRX);
  assign f7       = fields.alt ? F7_ALT : F7_BASE;

  // Field placement per instruction format
  always_comb begin
    word_c    = NOP_WORD;
    bad_class = 1'b0;
    case (fields.cls)
      ENC_LUI:    word_c = {fields.imm[31:12], fields.rd, OPC_LUI};
      ENC_AUIPC:  word_c = {fields.imm[31:12], fields.rd, OPC_AUIPC};
      ENC_JAL:    word_c = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                            fields.imm[19:12], fields.rd, OPC_JAL};
      ENC_JALR:   word_c = {fields.imm[11:0], fields.rs1, 3'b000, fields.rd, OPC_JALR};
      ENC_LOAD:   word_c = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OPC_LOAD};
      ENC_OPIMM: begin
        if (is_shift) begin
          word_c = {f7, fields.imm[4:0], fields.rs1, fields.funct3, fields.rd, OPC_OPIMM};
        end else begin
          word_c = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OPC_OPIMM};
        end
      end
      ENC_BRANCH: word_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                            fields.funct3, fields.imm[4:1], fields.imm[11], OPC_BRANCH};
      ENC_STORE:  word_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                            fields.imm[4:0], OPC_STORE};
      ENC_OP:     word_c = {f7, fields.rs2, fields.rs1, fields.funct3, fields.rd, OPC_OP};
      default:    bad_class = 1'b1;
    endcase
  end

  // Immediate range check; silent truncation when the check is compiled out
  always_comb begin
    range_err = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    case (fields.cls)
      ENC_LUI, ENC_AUIPC: range_err = (fields.imm[11:0] != 12'd0);
      ENC_JAL:            range_err = !fits_signed(fields.imm, 20) || fields.imm[0];
      ENC_JALR, ENC_LOAD,
      ENC_STORE:          range_err = !fits_signed(fields.imm, 11);
      ENC_OPIMM: begin
        if (is_shift) begin
          range_err = (fields.imm[31:5] != 27'd0);
        end else begin
          range_err = !fits_signed(fields.imm, 11);
        end
      end
      ENC_BRANCH:         range_err = !fits_signed(fields.imm, 12) || fields.imm[0];
      default:            range_err = 1'b0;
    endcase
`endif
  end

  assign err_c = bad_class | range_err;

endmodule

// File: rtl/rv_inst_encoder.sv
// RV32I instruction encoder / imem loader. Accepts one field bundle per cycle
// while running, writes the encoded word one cycle later at consecutive word
// addresses starting at a programmable base, and pulses done after the last
// write. Optional immediate range checking: define IMM_RANGE_CHECK_EN.
module rv_inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              base_sel,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  enc_state_t        state;
  enc_state_t        state_n;
  logic              accept_c;
  logic              launch_c;
  enc_fields_t       fields;
  logic [XLEN-1:0]   word_c;
  logic              pack_err_c;
  logic [ADDR_W-1:0] ptr;
  logic              wrap_pending;

  assign fields = '{cls: in_class, funct3: in_funct3, alt: in_alt, rd: in_rd,
                    rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  rv_field_pack u_pack (
    .fields (fields),
    .word_c (word_c),
    .err_c  (pack_err_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and accept decode
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    launch_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          launch_c = 1'b1;
          state_n  = ST_RUN;
        end
      end
      ST_RUN: begin
        accept_c = in_valid;
        if (in_valid && in_last) begin
          state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Status outputs track the state being entered so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_n == ST_RUN);
      busy     <= (state_n != ST_IDLE);
      done     <= (state_n == ST_DONE);
    end
  end

  // Write port, address pointer, word count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      ptr          <= '0;
      wrap_pending <= 1'b0;
      count        <= '0;
      err          <= 1'b0;
    end else begin
      imem_we <= accept_c;
      if (launch_c) begin
        ptr          <= base_sel ? base_addr : BASE_ADDR;
        wrap_pending <= 1'b0;
        count        <= '0;
        err          <= 1'b0;
      end
      if (accept_c) begin
        imem_addr    <= ptr;
        imem_wdata   <= word_c;
        ptr          <= ptr + ADDR_W'(1);
        count        <= count + CNT_W'(1);
        // The write that follows the top address lands on 0 and flags it
        wrap_pending <= wrap_pending | (ptr == '1);
        err          <= err | pack_err_c | wrap_pending;
      end
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Bench for rv_inst_encoder: table-driven encodings checked through a
// write scoreboard, plus session, wrap, bad-class, range and reset sequences.
module tb_rv_inst_encoder;
  import rv_isa_pkg::*;

  localparam bit RC =
`ifdef IMM_RANGE_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  localparam int unsigned AW = 14;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst;
  logic start, base_sel, in_valid, in_alt, in_last;
  logic [AW-1:0] base_addr;
  logic [3:0] in_class;
  logic [2:0] in_funct3;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic in_ready, imem_we, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] count;

  logic s_start, s_in_valid, s_in_last;
  logic [1:0] s_base_addr;
  logic s_in_ready, s_we, s_busy, s_done, s_err;
  logic [1:0] s_addr;
  logic [31:0] s_wdata;
  logic [2:0] s_count;

  always #5 clk = ~clk;

  rv_inst_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_sel(base_sel), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_funct3(in_funct3),
    .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  rv_inst_encoder #(.ADDR_W(2), .BASE_ADDR('0)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .base_sel(1'b1), .base_addr(s_base_addr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_class(ENC_OPIMM), .in_funct3(3'd0),
    .in_alt(1'b0), .in_rd(5'd1), .in_rs1(5'd0), .in_rs2(5'd0), .in_imm(32'd5),
    .in_last(s_in_last), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
  );

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    bit          rng;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   word;
    logic          err;
  } exp_t;

  vec_t vt [NV];
  exp_t sb_q [$];

  int n_checks = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_addr;
  logic [AW:0]   exp_count;
  logic [31:0]   cur_word;
  logic          cur_flag;
  logic          err_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: record any accept in the scoreboard, then check any write
  task automatic step();
    exp_t e;
    if (in_valid && in_ready && !rst) begin
      err_model = err_model | cur_flag;
      sb_q.push_back('{exp_addr, cur_word, err_model});
      exp_addr = exp_addr + AW'(1);
    end
    @(posedge clk);
    #1;
    if (imem_we) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 32'(imem_we), 32'd0);
      end else begin
        e = sb_q.pop_front();
        exp_count = exp_count + (AW+1)'(1);
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", imem_wdata, e.word);
        check("wr_err", 32'(err), 32'(e.err));
        check("wr_count", 32'(count), 32'(exp_count));
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic last);
    in_valid  = 1'b1;
    in_class  = v.cls;
    in_funct3 = v.f3;
    in_alt    = v.alt;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
    in_last   = last;
    cur_word  = v.word;
    cur_flag  = (v.cls > 4'd8) | (v.rng & RC);
  endtask

  task automatic start_session(input logic sel, input logic [AW-1:0] base);
    idle();
    start     = 1'b1;
    base_sel  = sel;
    base_addr = base;
    step();
    start     = 1'b0;
    exp_addr  = sel ? base : '0;
    exp_count = '0;
    err_model = 1'b0;
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    check("start_err", 32'(err), 32'd0);
    check("start_count", 32'(count), 32'd0);
  endtask

  // Called right after the step that accepted the last bundle (FLUSH cycle)
  task automatic end_session(input int n);
    check("flush_ready", 32'(in_ready), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    idle();
    step();
    check("done_pulse", 32'(done), 32'd1);
    check("done_count", 32'(count), 32'(n));
    check("done_err", 32'(err), 32'(err_model));
    step();
    check("post_done", 32'(done), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    vt[0]  = '{ENC_OPIMM,  3'd0, 1'b0, 5'd1,  5'd0, 5'd7, 32'd5,          32'h00500093, 1'b0};
    vt[1]  = '{ENC_OP,     3'd0, 1'b1, 5'd3,  5'd1, 5'd2, 32'd0,          32'h402081B3, 1'b0};
    vt[2]  = '{ENC_STORE,  3'd2, 1'b0, 5'd31, 5'd1, 5'd2, 32'd8,          32'h0020A423, 1'b0};
    vt[3]  = '{ENC_BRANCH, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3, 1'b0};
    vt[4]  = '{ENC_LUI,    3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h12345000,   32'h123452B7, 1'b0};
    vt[5]  = '{ENC_AUIPC,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h00001000,   32'h00001097, 1'b0};
    vt[6]  = '{ENC_JAL,    3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'd8,          32'h008000EF, 1'b0};
    vt[7]  = '{ENC_JALR,   3'd3, 1'b0, 5'd0,  5'd1, 5'd0, 32'd0,          32'h00008067, 1'b0};
    vt[8]  = '{ENC_LOAD,   3'd2, 1'b0, 5'd5,  5'd2, 5'd0, 32'hFFFFFFFC,   32'hFFC12283, 1'b0};
    vt[9]  = '{ENC_OPIMM,  3'd5, 1'b1, 5'd1,  5'd2, 5'd0, 32'd3,          32'h40315093, 1'b0};
    vt[10] = '{ENC_OP,     3'd7, 1'b0, 5'd4,  5'd5, 5'd6, 32'd0,          32'h0062F233, 1'b0};

    rst = 1'b1; start = 1'b0; base_sel = 1'b0; base_addr = '0;
    in_class = '0; in_funct3 = '0; in_alt = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; cur_word = '0; cur_flag = 1'b0; err_model = 1'b0;
    exp_addr = '0; exp_count = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_base_addr = 2'd3;
    idle();
    repeat (3) step();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b0;
    step();

    // All encodings in one session at base 0x10 with valid gaps
    start_session(1'b1, AW'(16'h0010));
    for (int i = 0; i < NV; i++) begin
      if (i % 4 == 3) begin
        idle();
        step();
      end
      drive(vt[i], (i == NV - 1));
      step();
    end
    end_session(NV);

    // Three bundles, gap, default base
    start_session(1'b0, AW'(16'h0123));
    drive(vt[0], 1'b0); step();
    idle(); step();
    drive(vt[1], 1'b0); step();
    drive(vt[2], 1'b1); step();
    end_session(3);

    // Unknown class writes NOP and flags err
    start_session(1'b1, AW'(16'h0200));
    v = '{4'd9, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 32'h00000013, 1'b0};
    drive(v, 1'b1); step();
    end_session(1);
    check("bad_class_err", 32'(err), 32'd1);

    // Misaligned JAL: written either way, err only with range checks
    start_session(1'b1, AW'(16'h0300));
    v = '{ENC_JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0020006F, 1'b1};
    drive(v, 1'b1); step();
    end_session(1);
    check("jal_err", 32'(err), 32'(RC));

    // Address wrap on the 2-bit instance
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    check("s_ready", 32'(s_in_ready), 32'd1);
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    check("s_we0", 32'(s_we), 32'd1);
    check("s_addr0", 32'(s_addr), 32'd3);
    check("s_data0", s_wdata, 32'h00500093);
    check("s_err0", 32'(s_err), 32'd0);
    s_in_last = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_in_last = 1'b0;
    check("s_we1", 32'(s_we), 32'd1);
    check("s_addr1", 32'(s_addr), 32'd0);
    check("s_err1", 32'(s_err), 32'd1);
    @(posedge clk); #1;
    check("s_done", 32'(s_done), 32'd1);
    check("s_count", 32'(s_count), 32'd2);
    @(posedge clk); #1;
    check("s_idle", 32'(s_busy), 32'd0);

    // Reset in the middle of a stream
    start_session(1'b1, AW'(16'h0100));
    drive(vt[0], 1'b0); step();
    drive(vt[1], 1'b0);
    rst = 1'b1;
    step();
    check("midrst_we", 32'(imem_we), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    idle();
    step();
    check("midrst_quiet", 32'(imem_we), 32'd0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
